// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared opcodes, format constants and helpers for the binary32 FPU
//  Revision : 1.0  initial release
// ============================================================================
package fpu_pkg;

  localparam logic [1:0]  OP_ADD = 2'd0;
  localparam logic [1:0]  OP_SUB = 2'd1;
  localparam logic [1:0]  OP_MUL = 2'd2;
  localparam logic [1:0]  OP_DIV = 2'd3;

  localparam int          BIAS   = 127;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Number of leading zeros in a 24-bit mantissa (24 when the value is zero).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_mant_div.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_mant_div
//  Purpose  : Combinational restoring divider for 24-bit normalised mantissas.
//             Produces a 25-bit quotient q = floor(num * 2^24 / den); with both
//             inputs in [2^23, 2^24) the ratio lies in (0.5, 2), so either bit
//             24 or bit 23 holds the leading one. norm_o flags the bit-24 case.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_mant_div (
  input  logic [23:0] num_i,
  input  logic [23:0] den_i,
  output logic [24:0] quo_o,
  output logic        norm_o
);

  logic [25:0] rem;

  // One restoring step per quotient bit, most significant first.
  always_comb begin
    rem   = {2'b00, num_i};
    quo_o = '0;
    for (int i = 24; i >= 0; i--) begin
      if (rem >= {2'b00, den_i}) begin
        quo_o[i] = 1'b1;
        rem      = rem - {2'b00, den_i};
      end
      rem = rem << 1;
    end
  end

  assign norm_o = quo_o[24];

endmodule
`default_nettype wire

// File: rtl/fpu.sv
`default_nettype none
// ============================================================================
//  Module   : fpu
//  Purpose  : Single-precision add/sub/mul/div with truncating rounding,
//             flush-to-zero denormals and one registered output stage.
//  Revision : 1.0  initial release
// ============================================================================
module fpu
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  operation,
  output logic [31:0] alu_output,
  output logic        overflow,
  output logic        underflow
);

  // ---------------------------------------------------------------- decode
  fp32_t       fa, fb;
  logic        a_zero, b_zero, a_special, b_special;
  logic [23:0] ma, mb;

  assign fa        = fp32_t'(a);
  assign fb        = fp32_t'(b);
  assign a_zero    = (fa.exp == 8'h00);
  assign b_zero    = (fb.exp == 8'h00);
  assign a_special = (fa.exp == 8'hFF);
  assign b_special = (fb.exp == 8'hFF);
  // Denormals collapse to zero mantissa so they behave as signed zero.
  assign ma        = a_zero ? 24'd0 : {1'b1, fa.frac};
  assign mb        = b_zero ? 24'd0 : {1'b1, fb.frac};

  // --------------------------------------------------------------- add/sub
  logic        sb_eff, a_larger, l_sign, same_sign;
  logic [7:0]  l_exp, s_exp, exp_diff;
  logic [23:0] l_m, s_m, s_aligned, norm_m;
  logic [24:0] sum;
  logic [4:0]  lz;
  logic [10:0] add_exp;
  logic [22:0] add_mant;

  assign sb_eff    = fb.sign ^ (operation == OP_SUB);
  // Exponent then mantissa ordering equals magnitude ordering.
  assign a_larger  = {fa.exp, ma} >= {fb.exp, mb};
  assign l_sign    = a_larger ? fa.sign : sb_eff;
  assign l_exp     = a_larger ? fa.exp  : fb.exp;
  assign s_exp     = a_larger ? fb.exp  : fa.exp;
  assign l_m       = a_larger ? ma      : mb;
  assign s_m       = a_larger ? mb      : ma;
  assign same_sign = (fa.sign == sb_eff);
  assign exp_diff  = l_exp - s_exp;
  assign s_aligned = s_m >> exp_diff;
  assign sum       = same_sign ? ({1'b0, l_m} + {1'b0, s_aligned})
                               : ({1'b0, l_m} - {1'b0, s_aligned});
  assign lz        = lzc24(sum[23:0]);
  assign norm_m    = sum[23:0] << lz;
  assign add_mant  = sum[24] ? sum[23:1] : norm_m[22:0];
  assign add_exp   = sum[24] ? ({3'b000, l_exp} + 11'd1)
                             : ({3'b000, l_exp} - {6'd0, lz});

  // -------------------------------------------------------------- multiply
  logic [47:0] prod;
  logic [10:0] mul_exp;
  logic [22:0] mul_mant;

  assign prod     = {24'd0, ma} * {24'd0, mb};
  assign mul_exp  = {3'b000, fa.exp} + {3'b000, fb.exp} - 11'(BIAS) + {10'd0, prod[47]};
  assign mul_mant = prod[47] ? prod[46:24] : prod[45:23];

  // ---------------------------------------------------------------- divide
  logic [24:0] quo;
  logic        quo_norm;
  logic [10:0] div_exp;
  logic [22:0] div_mant;

  fpu_mant_div u_mant_div (
    .num_i  (ma),
    .den_i  (mb),
    .quo_o  (quo),
    .norm_o (quo_norm)
  );

  assign div_exp  = {3'b000, fa.exp} - {3'b000, fb.exp} + 11'(BIAS) - {10'd0, ~quo_norm};
  assign div_mant = quo_norm ? quo[23:1] : quo[22:0];

  logic unused_bits;
  assign unused_bits = ^{prod[22:0], norm_m[23]};

  // ---------------------------------------------------------------- select
  logic        bypass, bypass_ovf, zero_res, res_sign;
  logic [31:0] bypass_val;
  logic [10:0] res_exp;
  logic [22:0] res_mant;

  // Choose the active operation; bypass carries fully-formed special results.
  always_comb begin
    bypass     = 1'b0;
    bypass_val = '0;
    bypass_ovf = 1'b0;
    zero_res   = 1'b0;
    res_sign   = 1'b0;
    res_exp    = '0;
    res_mant   = '0;
    if (a_special || b_special) begin
      bypass     = 1'b1;
      bypass_val = QNAN;
    end else begin
      case (operation)
        OP_ADD, OP_SUB: begin
          res_sign = l_sign;
          res_exp  = add_exp;
          res_mant = add_mant;
          if (sum == 25'd0) begin
            // Cancellation yields +0; only two negative zeros keep the sign.
            zero_res = 1'b1;
            res_sign = a_zero & b_zero & fa.sign & sb_eff;
          end
        end
        OP_MUL: begin
          res_sign = fa.sign ^ fb.sign;
          res_exp  = mul_exp;
          res_mant = mul_mant;
          zero_res = a_zero | b_zero;
        end
        default: begin
          res_sign = fa.sign ^ fb.sign;
          res_exp  = div_exp;
          res_mant = div_mant;
          if (b_zero) begin
            bypass     = 1'b1;
            bypass_val = a_zero ? QNAN : {res_sign, 8'hFF, 23'd0};
            bypass_ovf = ~a_zero;
          end else begin
            zero_res = a_zero;
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ pack
  logic [31:0] result_d, result_q;
  logic        overflow_d, overflow_q, underflow_d, underflow_q;

  // Range-check the two's-complement exponent and assemble the word.
  always_comb begin
    result_d    = '0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (bypass) begin
      result_d   = bypass_val;
      overflow_d = bypass_ovf;
    end else if (zero_res) begin
      result_d = {res_sign, 31'd0};
    end else if (res_exp[10] || (res_exp == 11'd0)) begin
      result_d    = {res_sign, 31'd0};
      underflow_d = 1'b1;
    end else if (res_exp >= 11'd255) begin
      result_d   = {res_sign, 8'hFF, 23'd0};
      overflow_d = 1'b1;
    end else begin
      result_d = {res_sign, res_exp[7:0], res_mant};
    end
  end

  // Output register; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign alu_output = result_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu
//  Purpose  : Self-checking bench for fpu: exact-arithmetic reference model,
//             directed vectors and randomized back-to-back traffic.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fpu;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic [1:0]  op  = '0;
  logic [31:0] alu_output;
  logic        overflow, underflow;

  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  logic [33:0] cmp_exp;
  bit          cmp_en;

  fpu dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .operation  (op),
    .alu_output (alu_output),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // Values are {overflow, underflow, result}.
  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got res=%h ovf=%b unf=%b, expected res=%h ovf=%b unf=%b",
               name, act[31:0], act[33], act[32], req[31:0], req[33], req[32]);
    end
  endtask

  // Truncate m * 2^sc to a 24-bit significand and range-check.
  function automatic logic [33:0] pack(input bit s, input longint m_in, input int sc_in);
    longint m;
    int     sc, e;
    m  = m_in;
    sc = sc_in;
    if (m == 0) return {2'b00, s, 31'd0};
    while (m >= (longint'(1) << 24)) begin m = m >> 1; sc++; end
    while (m <  (longint'(1) << 23)) begin m = m << 1; sc--; end
    e = sc + 150;
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  // Reference: operand value = m * 2^(e-150); arithmetic done on exact integers.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
    bit     sx, sy, sl;
    int     ex, ey, el, es, d;
    longint mx, my, ml, ms, sal, m;
    sx = x[31]; sy = y[31];
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    if (ex == 255 || ey == 255) return {2'b00, QNAN};
    mx = (ex == 0) ? 64'd0 : {40'd0, 1'b1, x[22:0]};
    my = (ey == 0) ? 64'd0 : {40'd0, 1'b1, y[22:0]};
    case (o)
      2'd0, 2'd1: begin
        if (o == 2'd1) sy = ~sy;
        if (mx == 0 && my == 0) return {2'b00, sx & sy, 31'd0};
        if (ex > ey || (ex == ey && mx >= my)) begin
          sl = sx; el = ex; ml = mx; es = ey; ms = my;
        end else begin
          sl = sy; el = ey; ml = my; es = ex; ms = mx;
        end
        d   = el - es;
        sal = (d > 40) ? 64'd0 : (ms >> d);
        m   = (sx == sy) ? (ml + sal) : (ml - sal);
        if (m == 0) return 34'd0;
        return pack(sl, m, el - 150);
      end
      2'd2: begin
        if (mx == 0 || my == 0) return {2'b00, sx ^ sy, 31'd0};
        return pack(sx ^ sy, mx * my, ex + ey - 300);
      end
      default: begin
        if (my == 0) return (mx == 0) ? {2'b00, QNAN} : {2'b10, sx ^ sy, 8'hFF, 23'd0};
        if (mx == 0) return {2'b00, sx ^ sy, 31'd0};
        return pack(sx ^ sy, (mx << 32) / my, ex - ey - 32);
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int         sel;
    sel = $urandom_range(0, 19);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel <= 3) e = 8'($urandom_range(1, 4));
    else if (sel <= 5) e = 8'($urandom_range(250, 254));
    else               e = 8'($urandom_range(110, 144));
    return {1'($urandom), e, ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom)};
  endfunction

  // Every cycle: expectation from the inputs sampled at this edge.
  initial begin
    forever begin
      @(posedge clk);
      cmp_exp = rst ? 34'd0 : model(a, b, op);
      cmp_en  = chk_en;
      #1;
      if (cmp_en) check("cycle", {overflow, underflow, alu_output}, cmp_exp);
    end
  end

  task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] o, input logic [33:0] req);
    @(negedge clk);
    a = x; b = y; op = o;
    check({name, "_model"}, model(x, y, o), req);
    @(posedge clk);
    #2;
    check(name, {overflow, underflow, alu_output}, req);
  endtask

  initial begin
    logic [31:0] x, y;
    // Reset held with live inputs present.
    a = 32'h3F80_0000; b = 32'h3F80_0000; op = OP_ADD;
    repeat (2) @(negedge clk);
    #1 check("reset_hold", {overflow, underflow, alu_output}, 34'd0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    directed("add_1_1",     32'h3F80_0000, 32'h3F80_0000, OP_ADD, {2'b00, 32'h4000_0000});
    directed("add_1_1p5",   32'h3F80_0000, 32'h3FC0_0000, OP_ADD, {2'b00, 32'h4020_0000});
    directed("add_neg",     32'hBFA0_0000, 32'h3FC0_0000, OP_ADD, {2'b00, 32'h3E80_0000});
    directed("add_align",   32'h42FE_1000, 32'h4187_8000, OP_ADD, {2'b00, 32'h430F_F800});
    directed("sub_cancel",  32'h3F80_0000, 32'h3F80_0000, OP_SUB, {2'b00, 32'h0000_0000});
    directed("sub_1_1p5",   32'h3F80_0000, 32'h3FC0_0000, OP_SUB, {2'b00, 32'hBF00_0000});
    directed("sub_neg",     32'hBFA0_0000, 32'h3FC0_0000, OP_SUB, {2'b00, 32'hC030_0000});
    directed("sub_align",   32'h42FE_1000, 32'h4187_8000, OP_SUB, {2'b00, 32'h42DC_3000});
    directed("mul_1_1p5",   32'h3F80_0000, 32'h3FC0_0000, OP_MUL, {2'b00, 32'h3FC0_0000});
    directed("mul_neg",     32'hBFA0_0000, 32'h3FC0_0000, OP_MUL, {2'b00, 32'hBFF0_0000});
    directed("mul_ovf",     32'h7F00_0000, 32'h4000_0000, OP_MUL, {2'b10, 32'h7F80_0000});
    directed("mul_unf",     32'h0080_0000, 32'h3F00_0000, OP_MUL, {2'b01, 32'h0000_0000});
    directed("div_1_1",     32'h3F80_0000, 32'h3F80_0000, OP_DIV, {2'b00, 32'h3F80_0000});
    directed("div_1_1p5",   32'h3F80_0000, 32'h3FC0_0000, OP_DIV, {2'b00, 32'h3F2A_AAAA});
    directed("div_neg",     32'hBFA0_0000, 32'h3FC0_0000, OP_DIV, {2'b00, 32'hBF55_5555});
    directed("div_by_zero", 32'h3F80_0000, 32'h0000_0000, OP_DIV, {2'b10, 32'h7F80_0000});
    directed("div_0_0",     32'h0000_0000, 32'h0000_0000, OP_DIV, {2'b00, 32'h7FC0_0000});
    for (int o = 0; o < 4; o++)
      directed("inf_operand", 32'h7F80_0000, 32'h3F80_0000, 2'(o), {2'b00, 32'h7FC0_0000});
    directed("denorm_add",  32'h0000_0001, 32'h3F80_0000, OP_ADD, {2'b00, 32'h3F80_0000});

    // Asynchronous reset between edges, then first post-reset result.
    directed("pre_reset",   32'h3F80_0000, 32'h3F80_0000, OP_ADD, {2'b00, 32'h4000_0000});
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3FC0_0000; op = OP_ADD;
    #1 rst = 1'b1;
    #1 check("async_reset", {overflow, underflow, alu_output}, 34'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2 check("post_reset_first", {overflow, underflow, alu_output}, {2'b00, 32'h4020_0000});

    // Randomized back-to-back traffic with mid-cycle input glitches.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 2'($urandom);
      #2;
      x = rand_fp();
      if ($urandom_range(0, 3) == 0)
        y = x ^ {1'($urandom), 8'd0, 23'($urandom_range(0, 255))};
      else
        y = rand_fp();
      a = x; b = y; op = 2'($urandom);
    end
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
